program_encoder: RTL and testbench
==================================

Name: program_encoder

Overview:
- Encoder counterpart to the core's control decoder. Accepts decoded instruction fields (class, opcode, operand) over a valid/ready handshake and packs each into a machine word.
- Writes words sequentially into instruction memory through a write port.
- Used by the test/boot path to load programs without an external assembler.
- Stops on the first Done-class instruction, or on address overflow.

Parameters:
- IW, 9, instruction word width. Bits [8:4] form the 5-bit control field {class[1:0], op[2:0]}; bits [3:0] are the operand field.
- AW, 8, instruction memory address width.

Ports:
- Clk input 1: system clock, rising edge.
- Reset_n input 1: asynchronous active-low reset.
- Start input 1: one-cycle pulse; begins a load session at BaseAddr. Ignored unless in IDLE.
- BaseAddr input AW: first write address, sampled on Start.
- CmdValid input 1: command fields valid.
- CmdReady output 1: encoder can accept a command this cycle.
- CmdClass input 2: 00 ALU, 01 branch, 10 load/store/done, 11 load-immediate.
- CmdOp input 3: opcode / ALU op / branch condition.
- CmdOperand input 4: register or immediate field.
- ImemWrEn output 1: instruction memory write strobe.
- ImemAddr output AW: write address.
- ImemWrData output IW: encoded word.
- Busy output 1: session active (any state except IDLE).
- Done output 1: one-cycle pulse on normal session end.
- Error output 1: sticky overflow flag, cleared only by the next Start or by reset.
- Count output AW+1: words written in the current session.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address 0.
- Encoding: ImemWrData = {CmdClass, CmdOp, CmdOperand}, registered on acceptance. Pure bit packing; every class/op combination is legal.
- Done-class word: CmdClass=10 with CmdOp not in {000, 001}.
- States:
  - IDLE: CmdReady=0. On Start: addr<=BaseAddr, Count<=0, Error<=0, go to ACCEPT.
  - ACCEPT: CmdReady=1. On CmdValid&CmdReady: latch encoded word, go to WRITE.
  - WRITE: CmdReady=0; ImemWrEn=1 for exactly this cycle, with the current ImemAddr/ImemWrData; Count+1.
    - If the word is Done-class: go to FINISH.
    - Else if addr == 2^AW-1: go to ERR (no wrap).
    - Else: addr+1, go to ACCEPT.
  - FINISH: Done=1 for one cycle, go to IDLE.
  - ERR: Error<=1, Busy=1, CmdReady=0; stays until Start (restarts the session) or reset.
- Throughput: one word per 2 cycles. Latency from accept to ImemWrEn: 1 cycle.
- ImemAddr and ImemWrData are held stable outside the write cycle (last written values).
- Start while Busy (except in ERR) is ignored.
- The last memory location is writable. Overflow is flagged only when a further non-Done word would be needed.
- Reset mid-session: immediate return to IDLE. Any in-flight write is dropped (ImemWrEn forced 0 asynchronously).
- CmdValid in IDLE/WRITE/FINISH: not accepted. The source must hold the command until CmdReady.

Optional Feature:
- Macro ENC_CHECKSUM_EN.
- Defined:
  - Adds output Checksum (IW bits).
  - XOR of every word written this session; cleared on Start and on reset.
  - Updates in the same cycle as ImemWrEn, so the new value is visible on the following cycle.
  - Holds its value after Done or ERR.
- Undefined: port absent; no checksum logic.

Test Plan:
- Reset, Start with BaseAddr=0x10; send ALU (00,010,0011) then Done (10,111,0000) -> writes 0x023 @0x10 and 0x170 @0x11. Done pulses 1 cycle after the second write. Count=2, Error=0.
- Load/store/li: send (10,000,0101), (10,001,0110), (11,101,1111) -> words 0x105, 0x116, 0x1DF at consecutive addresses. No Done; encoder back in ACCEPT with Busy=1.
- Backpressure/gaps: hold CmdValid low 3 cycles between commands -> no spurious ImemWrEn; CmdReady stays 1 in ACCEPT; accepted word count matches writes.
- Overflow: BaseAddr=0xFE; send three non-Done commands -> writes at 0xFE and 0xFF only; Error=1 after the second write; CmdReady=0. A third command is never accepted. A new Start clears Error.
- Reset mid-session: deassert Reset_n during a WRITE cycle -> ImemWrEn drops immediately; all outputs 0; IDLE after release.
- ENC_CHECKSUM_EN: words 0x023, 0x105, 0x170 -> Checksum = 0x056 after the final write.

Source files
------------

// File: rtl/program_encoder.sv
// program_encoder: packs decoded instruction fields {class, op, operand} into
// machine words and writes them sequentially into instruction memory.
// A session starts on Start, ends on the first Done-class word (Done pulse)
// or stops on address overflow (sticky Error until the next Start or reset).
// Optional feature macro: ENC_CHECKSUM_EN adds the Checksum output, which is the
// running XOR of the words written in the current session.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no session; commands not accepted
// ACCEPT | waiting for CmdValid; CmdReady high
// WRITE  | ImemWrEn high for this single cycle with latched addr/word
// FINISH | Done pulse after a Done-class word has been written
// ERR    | address space exhausted; sticky Error, waits for Start/reset

module program_encoder #(
    parameter int IW = 9,
    parameter int AW = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [AW-1:0] BaseAddr,
    input  logic          CmdValid,
    output logic          CmdReady,
    input  logic [1:0]    CmdClass,
    input  logic [2:0]    CmdOp,
    input  logic [3:0]    CmdOperand,
    output logic          ImemWrEn,
    output logic [AW-1:0] ImemAddr,
    output logic [IW-1:0] ImemWrData,
    output logic          Busy,
    output logic          Done,
    output logic          Error,
    output logic [AW:0]   Count
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [IW-1:0] Checksum
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCEPT = 3'd1;
    localparam logic [2:0] WRITE  = 3'd2;
    localparam logic [2:0] FINISH = 3'd3;
    localparam logic [2:0] ERR    = 3'd4;

    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   COUNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [AW-1:0] addr;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    logic [AW:0]   count;
    logic          error;
    logic          accept;
    logic          restart;
    logic          word_is_done;
    logic          addr_at_last;

    assign accept       = (state == ACCEPT) && CmdValid;
    assign restart      = Start && ((state == IDLE) || (state == ERR));
    // Class 10 with op 000/001 are load/store; the remaining class-10 ops end the program.
    assign word_is_done = (wr_data[IW-1 -: 2] == 2'b10) && (wr_data[IW-3 -: 3] > 3'b001);
    assign addr_at_last = (addr == ADDR_LAST);

    // Next-state selection for the session controller.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = ACCEPT;
            ACCEPT:  if (CmdValid) state_nxt = WRITE;
            WRITE: begin
                if (word_is_done)      state_nxt = FINISH;
                else if (addr_at_last) state_nxt = ERR;
                else                   state_nxt = ACCEPT;
            end
            FINISH:  state_nxt = IDLE;
            ERR:     if (Start) state_nxt = ACCEPT;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; async reset also kills an in-flight write strobe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Session address, word count and sticky overflow flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr  <= '0;
            count <= '0;
            error <= 1'b0;
        end else if (restart) begin
            addr  <= BaseAddr;
            count <= '0;
            error <= 1'b0;
        end else if (state == WRITE) begin
            count <= count + COUNT_ONE;
            if (!word_is_done) begin
                if (addr_at_last) error <= 1'b1;
                else              addr  <= addr + ADDR_ONE;
            end
        end
    end

    // Write port address/data, captured on acceptance and held until the next one.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if (accept) begin
            wr_addr <= addr;
            wr_data <= {CmdClass, CmdOp, CmdOperand};
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [IW-1:0] checksum;

    // Running XOR of written words, folded in during the write cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)            checksum <= '0;
        else if (restart)        checksum <= '0;
        else if (state == WRITE) checksum <= checksum ^ wr_data;
    end

    assign Checksum = checksum;
`endif

    assign CmdReady   = (state == ACCEPT);
    assign ImemWrEn   = (state == WRITE);
    assign ImemAddr   = wr_addr;
    assign ImemWrData = wr_data;
    assign Busy       = (state != IDLE);
    assign Done       = (state == FINISH);
    assign Error      = error;
    assign Count      = count;

endmodule

// File: tb/tb_program_encoder.sv
// Directed self-checking bench for program_encoder.
module tb_program_encoder;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic [7:0] BaseAddr;
    logic       CmdValid;
    logic       CmdReady;
    logic [1:0] CmdClass;
    logic [2:0] CmdOp;
    logic [3:0] CmdOperand;
    logic       ImemWrEn;
    logic [7:0] ImemAddr;
    logic [8:0] ImemWrData;
    logic       Busy;
    logic       Done;
    logic       Error;
    logic [8:0] Count;
`ifdef ENC_CHECKSUM_EN
    logic [8:0] Checksum;
`endif

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int wr_mark = 0;

    program_encoder dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .BaseAddr   (BaseAddr),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .CmdClass   (CmdClass),
        .CmdOp      (CmdOp),
        .CmdOperand (CmdOperand),
        .ImemWrEn   (ImemWrEn),
        .ImemAddr   (ImemAddr),
        .ImemWrData (ImemWrData),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error),
        .Count      (Count)
`ifdef ENC_CHECKSUM_EN
        ,
        .Checksum   (Checksum)
`endif
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (ImemWrEn === 1'b1) wr_seen++;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] base);
        BaseAddr = base;
        Start    = 1'b1;
        tick();
        Start    = 1'b0;
    endtask

    // Presents one command, waits (bounded) for acceptance, and checks the write cycle.
    task automatic send(input logic [1:0] cls, input logic [2:0] op, input logic [3:0] opnd,
                        input logic [7:0] exp_addr, input logic [8:0] exp_data);
        int n;
        CmdClass   = cls;
        CmdOp      = op;
        CmdOperand = opnd;
        CmdValid   = 1'b1;
        n = 0;
        while (CmdReady !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", CmdReady, 1);
        tick();
        CmdValid = 1'b0;
        chk("wr_en", ImemWrEn, 1);
        chk("wr_addr", ImemAddr, exp_addr);
        chk("wr_data", ImemWrData, exp_data);
        chk("ready_in_write", CmdReady, 0);
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; BaseAddr = '0; CmdValid = 1'b0;
        CmdClass = '0; CmdOp = '0; CmdOperand = '0;
        #23;
        chk("rst_wr_en", ImemWrEn, 0);
        chk("rst_ready", CmdReady, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_error", Error, 0);
        chk("rst_count", Count, 0);
        chk("rst_addr", ImemAddr, 0);
        chk("rst_data", ImemWrData, 0);
        Reset_n = 1'b1;
        tick();

        // ALU word then Done word
        pulse_start(8'h10);
        chk("s1_busy", Busy, 1);
        chk("s1_ready", CmdReady, 1);
        send(2'b00, 3'b010, 4'b0011, 8'h10, 9'h023);
        tick();
        chk("s1_idle_wr", ImemWrEn, 0);
        chk("s1_hold_addr", ImemAddr, 8'h10);
        chk("s1_hold_data", ImemWrData, 9'h023);
        chk("s1_count1", Count, 1);
        send(2'b10, 3'b111, 4'b0000, 8'h11, 9'h170);
        tick();
        chk("s1_done", Done, 1);
        chk("s1_count2", Count, 2);
        chk("s1_error", Error, 0);
        tick();
        chk("s1_done_pulse", Done, 0);
        chk("s1_busy_end", Busy, 0);
        chk("s1_ready_idle", CmdReady, 0);

        // load/store/li words, no Done
        wr_mark = wr_seen;
        pulse_start(8'h30);
        send(2'b10, 3'b000, 4'b0101, 8'h30, 9'h105);
        tick();
        chk("s2_ls_no_done", Done, 0);
        send(2'b10, 3'b001, 4'b0110, 8'h31, 9'h116);
        tick();
        chk("s2_ls_no_done2", Done, 0);
        send(2'b11, 3'b101, 4'b1111, 8'h32, 9'h1DF);
        tick();
        chk("s2_busy", Busy, 1);
        chk("s2_ready", CmdReady, 1);
        chk("s2_count", Count, 3);

        // backpressure gaps
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_wr_en", ImemWrEn, 0);
            chk("gap_ready", CmdReady, 1);
        end
        send(2'b00, 3'b001, 4'b0001, 8'h33, 9'h011);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap2_wr_en", ImemWrEn, 0);
            chk("gap2_ready", CmdReady, 1);
        end
        send(2'b10, 3'b010, 4'b0000, 8'h34, 9'h120);
        tick();
        chk("s2_done", Done, 1);
        chk("s2_count_end", Count, 5);
        chk("s2_writes", wr_seen - wr_mark, 5);
        tick();

        // overflow at top of address space
        pulse_start(8'hFE);
        send(2'b00, 3'b000, 4'b0001, 8'hFE, 9'h001);
        tick();
        chk("ov_no_err_yet", Error, 0);
        send(2'b01, 3'b011, 4'b0010, 8'hFF, 9'h0B2);
        tick();
        chk("ov_error", Error, 1);
        chk("ov_ready", CmdReady, 0);
        chk("ov_busy", Busy, 1);
        chk("ov_count", Count, 2);
        wr_mark = wr_seen;
        CmdClass = 2'b00; CmdOp = 3'b001; CmdOperand = 4'b0111; CmdValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ov_blocked_ready", CmdReady, 0);
        end
        chk("ov_no_write", wr_seen - wr_mark, 0);
        chk("ov_error_sticky", Error, 1);
        CmdValid = 1'b0;
        pulse_start(8'h40);
        chk("ov_restart_error", Error, 0);
        chk("ov_restart_count", Count, 0);
        chk("ov_restart_ready", CmdReady, 1);

        // Start while busy is ignored
        pulse_start(8'h80);
        send(2'b00, 3'b011, 4'b0100, 8'h40, 9'h034);
        tick();

        // reset during a write cycle
        send(2'b01, 3'b000, 4'b1000, 8'h41, 9'h088);
        Reset_n = 1'b0;
        #1;
        chk("mr_wr_en", ImemWrEn, 0);
        chk("mr_busy", Busy, 0);
        chk("mr_count", Count, 0);
        chk("mr_addr", ImemAddr, 0);
        chk("mr_data", ImemWrData, 0);
        chk("mr_error", Error, 0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        tick();
        chk("mr_idle_busy", Busy, 0);
        chk("mr_idle_ready", CmdReady, 0);

        // three-word session with running checksum
        pulse_start(8'h20);
        send(2'b00, 3'b010, 4'b0011, 8'h20, 9'h023);
        tick();
        send(2'b10, 3'b000, 4'b0101, 8'h21, 9'h105);
        tick();
        send(2'b10, 3'b111, 4'b0000, 8'h22, 9'h170);
        tick();
        chk("cs_done", Done, 1);
        chk("cs_count", Count, 3);
`ifdef ENC_CHECKSUM_EN
        chk("cs_checksum", Checksum, 9'h056);
        tick();
        chk("cs_checksum_hold", Checksum, 9'h056);
`else
        tick();
`endif
        chk("cs_idle", Busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
